debug_host: RTL
===============

# debug_host

Host-side initiator for the UART debug protocol served by the MIPS debug unit. It sends a one-byte command through the UART transmitter. It then collects a fixed number of 32-bit response words from the UART receiver, assembling each word from four bytes sent LSB first, and presents each word on a valid-pulsed output. It sits between a local controller (FPGA-to-FPGA link or a hardware bench master) and a `Transmisor`/`Receptor` pair running at the same baud rate as the debug target.

## Interface
Parameters:
- `NB` = 32: response word width; fixed at 4 bytes.
- `DATA_BITS` = 8: UART byte width.
- `NB_CNT` = 8: width of the word-count request and of the word index.
- `TIMEOUT_CYCLES` = 2_000_000: idle cycles allowed between received bytes before the transaction is aborted.

Ports:
- `i_clk` input 1: single clock, rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_cmd_valid` input 1: request strobe; sampled only while `o_busy`=0.
- `i_cmd` input DATA_BITS: command byte to send.
- `i_num_words` input NB_CNT: number of response words expected (0..2^NB_CNT-1).
- `o_busy` output 1: high from the cycle after acceptance until the `o_done` cycle, inclusive.
- `o_uart_tx_ready` output 1: one-cycle start pulse to the transmitter.
- `o_uart_tx_data` output DATA_BITS: byte to transmit; held stable from the start pulse until `i_uart_tx_done`.
- `i_uart_tx_done` input 1: transmitter finished the byte.
- `i_uart_rx_ready` input 1: one-cycle strobe, received byte valid.
- `i_uart_rx_data` input DATA_BITS: received byte.
- `o_word_valid` output 1: one-cycle pulse, `o_word` complete.
- `o_word` output NB: assembled word; holds its value until the next word.
- `o_word_index` output NB_CNT: index of `o_word`, counting from 0 within the transaction.
- `o_done` output 1: one-cycle end-of-transaction pulse.
- `o_timeout` output 1: status of the last transaction, 1 = aborted; cleared on the next acceptance.

## Operation
- Reset values: all outputs are 0 and the state is IDLE. An assertion mid-transaction aborts immediately, with no `o_done`.
- State machine: IDLE → SEND → WAIT_TX → RECV → DONE → IDLE.
- IDLE:
  - `i_cmd_valid`=1 latches `i_cmd` and `i_num_words`, clears `o_timeout`, clears the byte and word counters, and moves to SEND.
  - Received bytes in this state are discarded.
- SEND: drives `o_uart_tx_ready`=1 for exactly one cycle with `o_uart_tx_data`=cmd, then moves to WAIT_TX.
- WAIT_TX:
  - Waits for `i_uart_tx_done`.
  - Then goes to DONE if num_words=0, otherwise to RECV.
  - Bytes arriving before `i_uart_tx_done` are discarded.
- RECV:
  - Each `i_uart_rx_ready` writes the byte into lane byte_cnt of the shift word: byte 0 goes to [7:0] and byte 3 to [31:24].
  - byte_cnt wraps 3 → 0.
  - On the 4th byte, `o_word` takes the full word. `o_word_valid` pulses and `o_word_index` = word_cnt, then word_cnt increments.
  - When word_cnt reaches num_words, the block moves to DONE.
- Timeout:
  - The counter is cleared on entering RECV and on every received byte.
  - Once it has counted TIMEOUT_CYCLES cycles with no byte, the block sets `o_timeout`=1 and moves to DONE.
  - A partial word is discarded and `o_word_valid` is not asserted for it.
- DONE: `o_done`=1 for one cycle, `o_busy` is still 1, and the next state is IDLE. Extra bytes received in DONE or IDLE are discarded.
- `i_cmd_valid` while `o_busy`=1 is ignored and never queued.
- A byte strobe in the same cycle the timeout expires counts as a received byte, and the timeout is not taken.

## Timing
- Acceptance at edge N: `o_busy`=1 and `o_uart_tx_ready`=1 from edge N+1 for one cycle.
- `i_uart_tx_done` at edge M: state becomes RECV (or DONE) at M+1.
- 4th byte strobe at edge K: `o_word_valid`, `o_word`, and `o_word_index` are valid at K+1.
- For the last word, `o_done` is asserted at K+2 and `o_busy` drops at K+3.
- num_words=0: `o_done` at M+1.
- Timeout: `o_done` occurs TIMEOUT_CYCLES+1 cycles after the last byte or RECV entry, at most.
- Minimum gap between transactions: `i_cmd_valid` is accepted in the first cycle with `o_busy`=0.

## Test plan
- Command 0x01, num_words=1, reply bytes 0x78,0x56,0x34,0x12 → one `o_word_valid` with `o_word`=0x12345678, index 0, then `o_done`, `o_timeout`=0.
- Command 0x02, num_words=3, words 0x00000000, 0xFFFFFFFF, 0xDEADBEEF → three pulses with indices 0, 1, 2 in order, then `o_done` two cycles after the last.
- num_words=0 with command 0x05 → exactly one `o_uart_tx_ready` carrying 0x05, `o_done` one cycle after `i_uart_tx_done`, no `o_word_valid`.
- TIMEOUT_CYCLES=50, num_words=2, only 5 bytes sent → one word valid, then `o_timeout`=1 and `o_done` 51 cycles after the 5th byte; a following 0xAA byte is discarded.
- Stray byte 0x33 before `i_uart_tx_done`, and `i_cmd_valid` pulsed while busy → the byte is not assembled and no second transmit occurs.
- `i_reset` asserted after 2 bytes of a word → all outputs 0 asynchronously; a new command after release assembles from byte lane 0.

Source files
------------

// File: rtl/debug_host.sv
// Host-side initiator for the UART debug protocol: sends one command byte, then
// assembles a fixed number of little-endian 32-bit response words from the receiver.
module debug_host #(
    parameter int NB             = 32,
    parameter int DATA_BITS      = 8,
    parameter int NB_CNT         = 8,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [DATA_BITS-1:0] i_cmd,
    input  logic [NB_CNT-1:0]    i_num_words,
    output logic                 o_busy,
    output logic                 o_uart_tx_ready,
    output logic [DATA_BITS-1:0] o_uart_tx_data,
    input  logic                 i_uart_tx_done,
    input  logic                 i_uart_rx_ready,
    input  logic [DATA_BITS-1:0] i_uart_rx_data,
    output logic                 o_word_valid,
    output logic [NB-1:0]        o_word,
    output logic [NB_CNT-1:0]    o_word_index,
    output logic                 o_done,
    output logic                 o_timeout
);

    localparam int NBYTES = NB / DATA_BITS;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_TX,
        S_RECV,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_BITS-1:0]  cmd_q, cmd_d;
    logic [NB_CNT-1:0]     num_words_q, num_words_d;
    logic [BW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [NB_CNT-1:0]     word_cnt_q, word_cnt_d;
    logic [NB-1:0]         shift_q, shift_d;
    logic [NB-1:0]         word_q, word_d;
    logic                  word_valid_q, word_valid_d;
    logic [NB_CNT-1:0]     word_index_q, word_index_d;
    logic                  timeout_q, timeout_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cmd_q        <= '0;
            num_words_q  <= '0;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            word_index_q <= '0;
            timeout_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            num_words_q  <= num_words_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            word_index_q <= word_index_d;
            timeout_q    <= timeout_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        num_words_d  = num_words_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        word_index_d = word_index_q;
        timeout_d    = timeout_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    cmd_d       = i_cmd;
                    num_words_d = i_num_words;
                    timeout_d   = 1'b0;
                    byte_cnt_d  = '0;
                    word_cnt_d  = '0;
                    state_d     = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (i_uart_tx_done) begin
                    tmo_cnt_d = '0;
                    state_d   = (num_words_q == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                // A byte in the expiry cycle wins over the timeout.
                if (word_cnt_q == num_words_q) begin
                    state_d = S_DONE;
                end else if (i_uart_rx_ready) begin
                    tmo_cnt_d = '0;
                    shift_d[byte_cnt_q*DATA_BITS +: DATA_BITS] = i_uart_rx_data;
                    if (byte_cnt_q == BYTE_LAST) begin
                        byte_cnt_d   = '0;
                        word_d       = shift_d;
                        word_valid_d = 1'b1;
                        word_index_d = word_cnt_q;
                        word_cnt_d   = word_cnt_q + NB_CNT'(1);
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy          = (state_q != S_IDLE);
    assign o_uart_tx_ready = (state_q == S_SEND);
    assign o_uart_tx_data  = cmd_q;
    assign o_done          = (state_q == S_DONE);
    assign o_word_valid    = word_valid_q;
    assign o_word          = word_q;
    assign o_word_index    = word_index_q;
    assign o_timeout       = timeout_q;

endmodule
